// File: rtl/mc_pc_ir_regs.sv
// PC, IR, MDR and ALUOut registers for the multicycle datapath.
// Also forms the memory address and next-PC value, and returns the opcode to the controller.
module mc_pc_ir_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCWrite,
  input  logic             PCWriteCond,
  input  logic             IorD,
  input  logic             IRWrite,
  input  logic [1:0]       PCSource,
  input  logic             Zero,
  input  logic [31:0]      ALUResult,
  input  logic [31:0]      MemData,
  output logic [31:0]      PC,
  output logic [31:0]      MemAddr,
  output logic [31:0]      Instr,
  output logic [5:0]       Op,
  output logic [31:0]      MDR,
  output logic [31:0]      ALUOut,
  output logic [CNT_W-1:0] FetchCount,
  output logic             MisalignErr
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic        pc_we;
  logic        pc_sel_ok;
  logic        pc_load;
  logic [31:0] pc_next;

  assign pc_we = PCWrite | (PCWriteCond & Zero);

  // The reserved select (11) disables the PC write entirely.
  always_comb begin
    pc_next   = PC;
    pc_sel_ok = 1'b1;
    case (PCSource)
      2'b00:   pc_next = ALUResult;
      2'b01:   pc_next = ALUOut;
      2'b10:   pc_next = {PC[31:28], Instr[25:0], 2'b00};
      default: pc_sel_ok = 1'b0;
    endcase
  end

  assign pc_load = pc_we & pc_sel_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      PC          <= RESET_PC;
      Instr       <= '0;
      MDR         <= '0;
      ALUOut      <= '0;
      FetchCount  <= '0;
      MisalignErr <= 1'b0;
    end else begin
      if (pc_load) begin
        PC <= pc_next;
        if (pc_next[1:0] != 2'b00)
          MisalignErr <= 1'b1;
      end
      if (IRWrite) begin
        Instr <= MemData;
        if (FetchCount != CNT_MAX)
          FetchCount <= FetchCount + CNT_W'(1);
      end
      MDR    <= MemData;
      ALUOut <= ALUResult;
    end
  end

  assign MemAddr = IorD ? ALUOut : PC;
  assign Op      = Instr[31:26];

endmodule
